// File: rtl/cam_sccb_arb.sv
// Two-requester arbiter in front of a single SCCB/I2C driver.
// Round-robin on ties, timeout abort, and a forced idle gap after every response.
module cam_sccb_arb #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd20000,
  parameter logic [3:0]  GAP_CYC     = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        rh_wl0,
  input  logic        rh_wl1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  input  logic        i2c_done,
  input  logic [7:0]  i2c_data_r
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  gap_q, gap_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        rh_wl_q, rh_wl_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    gap_d        = gap_q;
    tcnt_d       = tcnt_q;
    rh_wl_d      = rh_wl_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      StIdle: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (req0 || req1) begin
          // On a tie the requester not granted last wins.
          owner_d = (req0 && req1) ? ~last_grant_q : req1;
          rh_wl_d = owner_d ? rh_wl1 : rh_wl0;
          addr_d  = owner_d ? addr1  : addr0;
          wdata_d = owner_d ? wdata1 : wdata0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        tcnt_d  = 16'd0;
        state_d = StWait;
      end
      StWait: begin
        // Driver completion takes priority over a coincident timeout.
        if (i2c_done) begin
          rdata_d = i2c_data_r;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (tcnt_q == TIMEOUT_CYC - 16'd1) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      StResp: begin
        last_grant_d = owner_q;
        gap_d        = GAP_CYC;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      gap_q        <= 4'd0;
      tcnt_q       <= 16'd0;
      rh_wl_q      <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      gap_q        <= gap_d;
      tcnt_q       <= tcnt_d;
      rh_wl_q      <= rh_wl_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    i2c_exec   = (state_q == StIssue);
    ack0       = (state_q == StResp) && !owner_q;
    ack1       = (state_q == StResp) && owner_q;
    busy       = (state_q != StIdle);
    err        = err_q;
    rdata      = rdata_q;
    i2c_rh_wl  = rh_wl_q;
    i2c_addr   = addr_q;
    i2c_data_w = wdata_q;
  end

endmodule

// File: tb/tb_cam_sccb_arb.sv
// Self-checking bench for cam_sccb_arb: driver model, ack scoreboard, scenario tasks.
module tb_cam_sccb_arb;

  localparam int TO  = 100;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        rh_wl0 = 1'b0, rh_wl1 = 1'b0;
  logic [15:0] addr0 = 16'h0, addr1 = 16'h0;
  logic [7:0]  wdata0 = 8'h0, wdata1 = 8'h0;
  logic        ack0, ack1, err, busy, i2c_exec, i2c_rh_wl;
  logic [7:0]  rdata, i2c_data_w;
  logic [15:0] i2c_addr;
  logic        i2c_done = 1'b0;
  logic [7:0]  i2c_data_r = 8'h0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       owner;
    logic       err;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   last_owner = 1;

  bit         drv_on = 1'b1;
  int         drv_delay = 30;
  logic [7:0] drv_data = 8'h00;
  int         drv_cnt = -1;

  cam_sccb_arb #(
    .TIMEOUT_CYC(16'(TO)),
    .GAP_CYC    (4'(GAP))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .rh_wl0    (rh_wl0),
    .rh_wl1    (rh_wl1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .i2c_exec  (i2c_exec),
    .i2c_rh_wl (i2c_rh_wl),
    .i2c_addr  (i2c_addr),
    .i2c_data_w(i2c_data_w),
    .i2c_done  (i2c_done),
    .i2c_data_r(i2c_data_r)
  );

  always #5 clk = ~clk;

  // I2C driver model: answers drv_delay cycles after the exec pulse.
  always @(negedge clk) begin
    i2c_done = 1'b0;
    if (drv_cnt > 0) begin
      drv_cnt--;
      if (drv_cnt == 0) begin
        i2c_done   = 1'b1;
        i2c_data_r = drv_data;
        drv_cnt    = -1;
      end
    end
    if (i2c_exec && drv_on) drv_cnt = drv_delay;
  end

  // Scoreboard monitor: every ack must match the oldest expected response.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_ack ack0=%0b ack1=%0b required no ack", ack0, ack1);
      end else begin
        mon_e = sb.pop_front();
        last_owner = int'(mon_e.owner);
        if ({ack1, ack0, err, rdata} !== {mon_e.owner, ~mon_e.owner, mon_e.err, mon_e.rdata}) begin
          failures++;
          $display("FAIL sb_response ack1=%0b ack0=%0b err=%0b rdata=%02h required ack1=%0b err=%0b rdata=%02h",
                   ack1, ack0, err, rdata, mon_e.owner, mon_e.err, mon_e.rdata);
        end
      end
    end
  end

  task automatic wait_exec(input int limit, output int cyc, output bit found);
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (i2c_exec) found = 1'b1;
    end
  endtask

  task automatic wait_ack(input int limit, output int cyc, output bit found);
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, i2c_exec, ack0, ack1, err, i2c_rh_wl} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags busy/exec/ack0/ack1/err/rh_wl=%06b required 000000",
               {busy, i2c_exec, ack0, ack1, err, i2c_rh_wl});
    end
    checks++;
    if (rdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_rdata got=%02h required 00", rdata);
    end
    checks++;
    if (i2c_addr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_addr got=%04h required 0000", i2c_addr);
    end
    checks++;
    if (i2c_data_w !== 8'h00) begin
      failures++;
      $display("FAIL reset_data_w got=%02h required 00", i2c_data_w);
    end
    rst = 1'b0;
    last_owner = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || i2c_exec !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req busy=%0b exec=%0b required 0 0", busy, i2c_exec);
    end
  endtask

  task automatic test_single_write();
    int cyc;
    bit found;
    drv_on = 1'b1; drv_delay = 30; drv_data = 8'h00;
    addr0 = 16'h3008; wdata0 = 8'h82; rh_wl0 = 1'b0; req0 = 1'b1;
    sb.push_back('{owner: 1'b0, err: 1'b0, rdata: 8'h00});
    wait_exec(10, cyc, found);
    checks++;
    if (!found || cyc != 1) begin
      failures++;
      $display("FAIL write_exec_latency found=%0b cyc=%0d required 1 1", found, cyc);
    end
    checks++;
    if ({i2c_rh_wl, i2c_addr, i2c_data_w} !== {1'b0, 16'h3008, 8'h82}) begin
      failures++;
      $display("FAIL write_latch rh_wl=%0b addr=%04h data_w=%02h required 0 3008 82",
               i2c_rh_wl, i2c_addr, i2c_data_w);
    end
    // Owner drops req and scrambles its inputs mid-transaction.
    req0 = 1'b0; addr0 = 16'hFFFF; wdata0 = 8'h11;
    @(negedge clk);
    checks++;
    if (i2c_exec !== 1'b0) begin
      failures++;
      $display("FAIL write_exec_width exec=%0b required 0", i2c_exec);
    end
    wait_ack(100, cyc, found);
    checks++;
    if (!found || cyc != 30 || ack0 !== 1'b1 || ack1 !== 1'b0) begin
      failures++;
      $display("FAIL write_ack found=%0b cyc_after_exec=%0d ack0=%0b ack1=%0b required 1 31 1 0",
               found, cyc + 1, ack0, ack1);
    end
    checks++;
    if ({i2c_addr, i2c_data_w} !== {16'h3008, 8'h82}) begin
      failures++;
      $display("FAIL write_hold addr=%04h data_w=%02h required 3008 82", i2c_addr, i2c_data_w);
    end
  endtask

  task automatic test_read();
    int cyc;
    bit found;
    drv_delay = 10; drv_data = 8'h56;
    rh_wl1 = 1'b1; addr1 = 16'h300A; wdata1 = 8'h00; req1 = 1'b1;
    sb.push_back('{owner: 1'b1, err: 1'b0, rdata: 8'h56});
    wait_exec(20, cyc, found);
    checks++;
    if (!found || cyc != GAP + 2) begin
      failures++;
      $display("FAIL read_gap found=%0b cyc=%0d required 1 %0d", found, cyc, GAP + 2);
    end
    checks++;
    if ({i2c_rh_wl, i2c_addr} !== {1'b1, 16'h300A}) begin
      failures++;
      $display("FAIL read_latch rh_wl=%0b addr=%04h required 1 300a", i2c_rh_wl, i2c_addr);
    end
    req1 = 1'b0;
    wait_ack(50, cyc, found);
    checks++;
    if (!found || cyc != 11 || ack1 !== 1'b1) begin
      failures++;
      $display("FAIL read_ack found=%0b cyc=%0d ack1=%0b required 1 11 1", found, cyc, ack1);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (rdata !== 8'h56 || err !== 1'b0) begin
      failures++;
      $display("FAIL read_hold rdata=%02h err=%0b required 56 0", rdata, err);
    end
  endtask

  task automatic test_tie();
    int cyc;
    bit found;
    int first;
    int own;
    int extra;
    first = (last_owner == 1) ? 0 : 1;
    drv_delay = 5; drv_data = 8'hA5;
    addr0 = 16'h1000; addr1 = 16'h2000; rh_wl0 = 1'b0; rh_wl1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      own = first ^ (i & 1);
      sb.push_back('{owner: own[0], err: 1'b0, rdata: 8'hA5});
    end
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      own = first ^ (i & 1);
      wait_exec(30, cyc, found);
      checks++;
      if (!found || (i > 0 && cyc != GAP + 2)) begin
        failures++;
        $display("FAIL tie_gap idx=%0d found=%0b cyc=%0d required 1 %0d", i, found, cyc, GAP + 2);
      end
      checks++;
      if (i2c_addr !== (own == 1 ? 16'h2000 : 16'h1000)) begin
        failures++;
        $display("FAIL tie_owner_addr idx=%0d addr=%04h required owner %0d", i, i2c_addr, own);
      end
      wait_ack(30, cyc, found);
      checks++;
      if (!found || ack1 !== own[0] || ack0 !== ~own[0]) begin
        failures++;
        $display("FAIL tie_ack idx=%0d found=%0b ack0=%0b ack1=%0b required owner %0d",
                 i, found, ack0, ack1, own);
      end
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (i2c_exec || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL tie_no_regrant active_cycles=%0d required 0", extra);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit found;
    drv_on = 1'b0;
    addr0 = 16'h3100; rh_wl0 = 1'b1; req0 = 1'b1;
    sb.push_back('{owner: 1'b0, err: 1'b1, rdata: 8'h00});
    wait_exec(20, cyc, found);
    req0 = 1'b0;
    wait_ack(TO + 20, cyc, found);
    checks++;
    if (!found || cyc != TO + 1 || ack0 !== 1'b1) begin
      failures++;
      $display("FAIL timeout_ack found=%0b cyc=%0d ack0=%0b required 1 %0d 1", found, cyc, ack0, TO + 1);
    end
    checks++;
    if (err !== 1'b1 || rdata !== 8'h00) begin
      failures++;
      $display("FAIL timeout_err err=%0b rdata=%02h required 1 00", err, rdata);
    end
    drv_on = 1'b1; drv_delay = 3; drv_data = 8'h3C;
    rh_wl1 = 1'b1; addr1 = 16'h3200; req1 = 1'b1;
    sb.push_back('{owner: 1'b1, err: 1'b0, rdata: 8'h3C});
    wait_exec(20, cyc, found);
    req1 = 1'b0;
    wait_ack(30, cyc, found);
    checks++;
    if (!found || ack1 !== 1'b1 || err !== 1'b0 || rdata !== 8'h3C) begin
      failures++;
      $display("FAIL after_timeout found=%0b ack1=%0b err=%0b rdata=%02h required 1 1 0 3c",
               found, ack1, err, rdata);
    end
  endtask

  task automatic test_coincide();
    int cyc;
    bit found;
    drv_on = 1'b1; drv_delay = TO; drv_data = 8'h77;
    addr0 = 16'h3300; req0 = 1'b1;
    sb.push_back('{owner: 1'b0, err: 1'b0, rdata: 8'h77});
    wait_exec(20, cyc, found);
    req0 = 1'b0;
    wait_ack(TO + 20, cyc, found);
    checks++;
    if (!found || cyc != TO + 1 || err !== 1'b0 || rdata !== 8'h77) begin
      failures++;
      $display("FAIL coincide found=%0b cyc=%0d err=%0b rdata=%02h required 1 %0d 0 77",
               found, cyc, err, rdata, TO + 1);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit found;
    int activity;
    drv_on = 1'b1; drv_delay = 20; drv_data = 8'h99;
    addr0 = 16'h4444; req0 = 1'b1;
    wait_exec(20, cyc, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rstmid_exec found=%0b required 1", found);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1; req0 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, i2c_exec, ack0, ack1, err} !== 5'b0 || rdata !== 8'h00 || i2c_addr !== 16'h0) begin
      failures++;
      $display("FAIL rstmid_state flags=%05b rdata=%02h addr=%04h required 00000 00 0000",
               {busy, i2c_exec, ack0, ack1, err}, rdata, i2c_addr);
    end
    rst = 1'b0;
    last_owner = 1;
    activity = 0;
    repeat (30) begin
      @(negedge clk);
      if (ack0 || ack1 || busy) activity++;
    end
    checks++;
    if (activity != 0) begin
      failures++;
      $display("FAIL rstmid_late_done active_cycles=%0d required 0", activity);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_tie();
    test_timeout();
    test_coincide();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
